// File: rtl/mdu_pkg.sv
// mdu_pkg: operation and FSM state encodings shared by the multiply/divide unit
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_FIX  = 2'b11
    } mdu_state_e;

    localparam int MDU_ITER = 32;

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: iterative restoring radix-2 divider core on unsigned magnitudes
//  clk, resetn      clock, synchronous active-low reset
//  load_i           capture dividend_i/divisor_i, clear partial remainder
//  step_i           produce one quotient bit (MSB first)
//  quotient_o       quotient after WIDTH steps
//  remainder_o      remainder after WIDTH steps
module mdu_divider
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_ITER
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, diff;
    logic [WIDTH:0]   trial;
    logic             ge;

    // quo_q doubles as the dividend shift register: its MSB feeds the trial remainder
    // while quotient bits enter at the LSB. A stored remainder is always below the
    // divisor, so it fits WIDTH bits even though the trial needs WIDTH+1.
    always_comb begin
        trial = {rem_q, quo_q[WIDTH-1]};
        ge    = trial >= {1'b0, dvs_q};
        diff  = trial[WIDTH-1:0] - dvs_q;
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        if (load_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dvs_d = divisor_i;
        end else if (step_i) begin
            rem_d = ge ? diff : trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], ge};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle MULT/MULTU/DIV/DIVU unit producing the {hi,lo} result pair
//  clk, resetn         clock, synchronous active-low reset
//  start, op           launch op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU), sampled in IDLE only
//  src_a, src_b        multiplicand/dividend, multiplier/divisor
//  flush               cancel in-flight op; wins over a same-cycle start
//  busy                op in progress
//  done                one-cycle pulse, result_hi/result_lo valid
//  result_hi/lo        MUL: product high/low; DIV: remainder/quotient
//  Build option MDU_FAST_MUL_EN: single-cycle multiply registered at the start edge.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_ITER,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo
);

    mdu_state_e         state_q, state_d;
    mdu_op_e            op_in;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d, mul_res;
    logic [WIDTH-1:0]   mcand_q, mcand_d, hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
    logic [WIDTH:0]     mul_sum;
    logic               neg_q, neg_d, neg_r_q, neg_r_d, dz_q, dz_d, div_q, div_d;
    logic               done_q, done_d;
    logic               sgn_in, div_in, a_neg, b_neg, accept;
`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_mag;
`endif

    always_comb begin
        op_in   = mdu_op_e'(op);
        sgn_in  = op_in == MDU_MULT || op_in == MDU_DIV;
        div_in  = op_in == MDU_DIV || op_in == MDU_DIVU;
        a_neg   = sgn_in && src_a[WIDTH-1];
        b_neg   = sgn_in && src_b[WIDTH-1];
        a_mag   = a_neg ? -src_a : src_a;
        b_mag   = b_neg ? -src_b : src_b;
        accept  = state_q == S_IDLE && start && !flush;
        // prod_q holds {partial sum, remaining multiplier bits}; each step adds the
        // multiplicand when the multiplier LSB is set and shifts the pair right.
        mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, prod_q[0] ? mcand_q : {WIDTH{1'b0}}};
        mul_res = neg_q ? -prod_q : prod_q;
`ifdef MDU_FAST_MUL_EN
        fast_mag = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif
    end

    mdu_divider #(.WIDTH(WIDTH)) u_div (
        .clk         (clk),
        .resetn      (resetn),
        .load_i      (accept && div_in),
        .step_i      (state_q == S_DIV),
        .dividend_i  (a_mag),
        .divisor_i   (b_mag),
        .quotient_o  (quo),
        .remainder_o (rem)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        neg_d   = neg_q;
        neg_r_d = neg_r_q;
        dz_d    = dz_q;
        div_d   = div_q;
        done_d  = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    neg_d   = a_neg ^ b_neg;
                    neg_r_d = a_neg;
                    dz_d    = src_b == '0;
                    div_d   = div_in;
                    cnt_d   = '0;
`ifdef MDU_FAST_MUL_EN
                    if (div_in) state_d = S_DIV;
                    else begin
                        {hi_d, lo_d} = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
                        done_d       = 1'b1;
                    end
`else
                    state_d = div_in ? S_DIV : S_MUL;
                    prod_d  = {{WIDTH{1'b0}}, b_mag};
                    mcand_d = a_mag;
`endif
                end
                S_MUL, S_DIV: begin
                    if (state_q == S_MUL) prod_d = {mul_sum, prod_q[WIDTH-1:1]};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_FIX;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    // Divide by zero yields all-ones quotient regardless of signs; the
                    // remainder path naturally returns the original dividend.
                    if (div_q) begin
                        lo_d = dz_q ? {WIDTH{1'b1}} : (neg_q ? -quo : quo);
                        hi_d = neg_r_q ? -rem : rem;
                    end else begin
                        {hi_d, lo_d} = mul_res;
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
            neg_r_q <= 1'b0;
            dz_q    <= 1'b0;
            div_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q   <= neg_d;
            neg_r_q <= neg_r_d;
            dz_q    <= dz_d;
            div_q   <= div_d;
            done_q  <= done_d;
        end
    end

    assign busy      = state_q != S_IDLE;
    assign done      = done_q;
    assign result_hi = hi_q;
    assign result_lo = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: randomized and directed checks of mdu_unit against an arithmetic model
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] result_hi, result_lo;
    int          total = 0;
    int          bad = 0;

    mdu_unit dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result_hi (result_hi),
        .result_lo (result_lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        longint      p;
        logic [63:0] ua, ub;
        logic [31:0] q, r;
        sa = a;
        sb = b;
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            2'b00: begin p = longint'(sa) * longint'(sb); return p; end
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] o);
`ifdef MDU_FAST_MUL_EN
        return o[1] ? 34 : 1;
`else
        return 34;
`endif
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int poke_at, output int lat, output int busy_bad);
        int c;
        lat = 0;
        busy_bad = 0;
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 1;
        while (lat == 0 && c <= 60) begin
            if (done === 1'b1) lat = c;
            else begin
                if (busy !== 1'b1) busy_bad++;
                if (c == poke_at) begin
                    start = 1'b1; op = ~o; src_a = ~a; src_b = b ^ 32'h55;
                end
                @(posedge clk); #1;
                start = 1'b0;
                c++;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
        total++; if (result_hi !== 32'h0) begin bad++; $display("FAIL reset_hi got %h want 0", result_hi); end
        total++; if (result_lo !== 32'h0) begin bad++; $display("FAIL reset_lo got %h want 0", result_lo); end
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [1:0]  ops [10] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b11, 2'b00};
        logic [31:0] as  [10] = '{32'hFFFF_FFFF, -32'd3, 32'h8000_0000, -32'd7, 32'd100, 32'd5,
                                  32'h8000_0000, -32'd9, 32'd0, 32'd0};
        logic [31:0] bs  [10] = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd2, 32'd7, 32'd0,
                                  32'hFFFF_FFFF, 32'd0, 32'd0, 32'h1234_5678};
        int lat, bb;
        logic [63:0] exp;
        for (int i = 0; i < 10; i++) begin
            run_op(ops[i], as[i], bs[i], 0, lat, bb);
            exp = model(ops[i], as[i], bs[i]);
            total++; if (lat != exp_lat(ops[i])) begin bad++; $display("FAIL dir_latency[%0d] got %0d want %0d", i, lat, exp_lat(ops[i])); end
            total++; if (bb != 0 || busy !== 1'b0) begin bad++; $display("FAIL dir_busy[%0d] got bad_cycles=%0d busy_at_done=%b want 0/0", i, bb, busy); end
            total++; if ({result_hi, result_lo} !== exp) begin bad++; $display("FAIL dir_result[%0d] got %h want %h", i, {result_hi, result_lo}, exp); end
            @(posedge clk); #1;
            total++; if (done !== 1'b0 || {result_hi, result_lo} !== exp) begin bad++; $display("FAIL dir_hold[%0d] got done=%b res=%h want 0/%h", i, done, {result_hi, result_lo}, exp); end
        end
    endtask

    task automatic test_random();
        int lat, bb;
        logic [1:0]  o;
        logic [31:0] a, b;
        logic [63:0] exp;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 20));
                2: b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            run_op(o, a, b, 0, lat, bb);
            exp = model(o, a, b);
            total++; if (lat != exp_lat(o) || bb != 0) begin bad++; $display("FAIL rnd_timing[%0d] got lat=%0d busy_bad=%0d want %0d/0", i, lat, bb, exp_lat(o)); end
            total++; if ({result_hi, result_lo} !== exp) begin bad++; $display("FAIL rnd_result[%0d] op=%0d a=%h b=%h got %h want %h", i, o, a, b, {result_hi, result_lo}, exp); end
        end
    endtask

    task automatic test_start_busy();
        int lat, bb;
        run_op(2'b11, 32'd1000, 32'd33, 5, lat, bb);
        total++; if (lat != 34 || bb != 0) begin bad++; $display("FAIL busy_start_timing got lat=%0d busy_bad=%0d want 34/0", lat, bb); end
        total++; if ({result_hi, result_lo} !== {32'd10, 32'd30}) begin bad++; $display("FAIL busy_start_result got %h want %h", {result_hi, result_lo}, {32'd10, 32'd30}); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int lat, bb, seen;
        logic [63:0] exp;
        run_op(2'b11, 32'd100, 32'd7, 0, lat, bb);
        @(posedge clk); #1;
        op = 2'b10; src_a = -32'd1000; src_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL flush_state got busy=%b done=%b want 0/0", busy, done); end
        total++; if ({result_hi, result_lo} !== {32'd2, 32'd14}) begin bad++; $display("FAIL flush_keep got %h want %h", {result_hi, result_lo}, {32'd2, 32'd14}); end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (done !== 1'b0) seen++; end
        total++; if (seen != 0) begin bad++; $display("FAIL flush_no_done got %0d done cycles want 0", seen); end
        op = 2'b10; src_a = 32'd77; src_b = 32'd5; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        seen = (busy !== 1'b0) ? 1 : 0;
        repeat (40) begin @(posedge clk); #1; if (done !== 1'b0 || busy !== 1'b0) seen++; end
        total++; if (seen != 0) begin bad++; $display("FAIL start_flush_launch got %0d active cycles want 0", seen); end
        run_op(2'b10, -32'd1000, 32'd3, 0, lat, bb);
        exp = model(2'b10, -32'd1000, 32'd3);
        total++; if (lat != 34 || {result_hi, result_lo} !== exp) begin bad++; $display("FAIL flush_restart got lat=%0d res=%h want 34/%h", lat, {result_hi, result_lo}, exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop();
        int seen;
        op = 2'b11; src_a = 32'd5000; src_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_mid_state got busy=%b done=%b want 0/0", busy, done); end
        total++; if ({result_hi, result_lo} !== 64'h0) begin bad++; $display("FAIL rst_mid_result got %h want 0", {result_hi, result_lo}); end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (done !== 1'b0) seen++; end
        total++; if (seen != 0) begin bad++; $display("FAIL rst_mid_no_done got %0d done cycles want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_busy();
        test_flush();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
